// File: rtl/ethernet_header_remover_pkg.sv
// Shared Ethernet II definitions for the RX header remover: header layout, broadcast
// address, FSM state encoding and the header unpacking helper.
package eth_hdr_pkg;

    localparam int          ETH_HDR_BYTES = 14;
    localparam logic [47:0] ETH_BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    typedef struct packed {
        logic [15:0] ethertype;
        logic [47:0] src_mac;
        logic [47:0] dst_mac;
    } eth_hdr_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DROP   = 2'd3
    } eth_state_e;

    // Wire byte 0 lands in the MSB of each MAC/type field (network order).
    function automatic eth_hdr_t eth_hdr_pack(input logic [8*ETH_HDR_BYTES-1:0] b);
        eth_hdr_t h;
        for (int i = 0; i < 6; i++) begin
            h.dst_mac[47-8*i -: 8] = b[8*i +: 8];
            h.src_mac[47-8*i -: 8] = b[8*(6+i) +: 8];
        end
        h.ethertype = {b[8*12 +: 8], b[8*13 +: 8]};
        return h;
    endfunction

endpackage

// File: rtl/ethernet_header_remover_if.sv
// Stream bundle of the header remover: frame input, re-aligned payload output and
// parsed-header metadata output.
interface ethernet_header_remover_if #(
    parameter int DATA_W = 512
);
    logic [DATA_W-1:0]   s_axis_tdata;
    logic [DATA_W/8-1:0] s_axis_tkeep;
    logic                s_axis_tlast;
    logic                s_axis_tvalid;
    logic                s_axis_tready;

    logic [DATA_W-1:0]   m_axis_tdata;
    logic [DATA_W/8-1:0] m_axis_tkeep;
    logic                m_axis_tlast;
    logic                m_axis_tvalid;
    logic                m_axis_tready;

    logic [111:0]        m_meta_tdata;
    logic                m_meta_tvalid;
    logic                m_meta_tready;

    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
        output m_axis_tready,
        input  m_meta_tdata, m_meta_tvalid,
        output m_meta_tready
    );

    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
        input  m_axis_tready,
        output m_meta_tdata, m_meta_tvalid,
        input  m_meta_tready
    );
endinterface

// File: rtl/ethernet_header_remover_out_reg.sv
// One-deep AXI-Stream output register; accepts a new word whenever it is empty or
// its current word is being taken in the same cycle.
module eth_axis_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    input  logic         i_ready
);
    logic [W-1:0] r_data;
    logic         r_valid;

    assign o_ready = !r_valid || i_ready;
    assign o_data  = r_data;
    assign o_valid = r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) r_data <= i_data;
        end
    end
endmodule

// File: rtl/ethernet_header_remover.sv
// Strips the 14-byte Ethernet II header, re-aligns payload to byte 0 and emits the header as metadata.
// Optional destination-MAC filter: define ETH_HDR_REMOVER_FILTER_EN.
module ethernet_header_remover
    import eth_hdr_pkg::*;
#(
    parameter int DATA_W    = 512,
    parameter int HDR_BYTES = ETH_HDR_BYTES,
    parameter int CNT_W     = 32
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    ethernet_header_remover_if.slave bus,
    input  logic [47:0]              my_mac,
    output logic [CNT_W-1:0]         runt_cnt,
    output logic [CNT_W-1:0]         drop_cnt
);
    localparam int NB = DATA_W / 8;
    localparam int R  = NB - HDR_BYTES;
    localparam int OW = DATA_W + NB + 1;

    eth_state_e      r_state, w_state_nxt;
    logic [8*R-1:0]  r_res_data;
    logic [R-1:0]    r_res_keep;
    logic [CNT_W-1:0] r_runt_cnt;

    eth_hdr_t        w_hdr;
    logic [R-1:0]    w_in_res_keep;
    logic            w_in_acc, w_runt, w_dst_ok;
    logic            w_s_ready, w_res_load, w_runt_inc, w_meta_load;
    logic            w_pay_valid, w_pay_rdy, w_meta_rdy;
    logic [OW-1:0]   w_pay_in, w_pay_out;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_hdr         = eth_hdr_pack(bus.s_axis_tdata[8*HDR_BYTES-1:0]);
    assign w_in_res_keep = bus.s_axis_tkeep[NB-1:HDR_BYTES];
    assign w_in_acc      = bus.s_axis_tvalid && w_s_ready;
    assign w_runt        = bus.s_axis_tlast && !(|w_in_res_keep);

`ifdef ETH_HDR_REMOVER_FILTER_EN
    logic             w_drop_inc;
    logic [CNT_W-1:0] r_drop_cnt;
    assign w_dst_ok = (w_hdr.dst_mac == my_mac) || (w_hdr.dst_mac == ETH_BCAST_MAC);
    assign drop_cnt = r_drop_cnt;
`else
    logic w_unused_mac;
    assign w_unused_mac = ^my_mac;
    assign w_dst_ok     = 1'b1;
    assign drop_cnt     = '0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_s_ready   = 1'b0;
        w_pay_valid = 1'b0;
        w_pay_in    = '0;
        w_meta_load = 1'b0;
        w_res_load  = 1'b0;
        w_runt_inc  = 1'b0;
`ifdef ETH_HDR_REMOVER_FILTER_EN
        w_drop_inc  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                // At most one frame of lookahead: the header slot must be free first.
                w_s_ready = w_meta_rdy;
                if (w_in_acc) begin
                    if (w_runt) begin
                        w_runt_inc = 1'b1;
                    end else if (!w_dst_ok) begin
`ifdef ETH_HDR_REMOVER_FILTER_EN
                        w_drop_inc = 1'b1;
`endif
                        w_state_nxt = bus.s_axis_tlast ? IDLE : DROP;
                    end else begin
                        w_meta_load = 1'b1;
                        w_res_load  = 1'b1;
                        w_state_nxt = bus.s_axis_tlast ? FLUSH : STREAM;
                    end
                end
            end
            STREAM: begin
                w_s_ready = w_pay_rdy;
                if (w_in_acc) begin
                    w_pay_valid = 1'b1;
                    w_res_load  = 1'b1;
                    w_pay_in    = {1'b0, bus.s_axis_tkeep[HDR_BYTES-1:0], r_res_keep,
                                   bus.s_axis_tdata[8*HDR_BYTES-1:0], r_res_data};
                    if (bus.s_axis_tlast) begin
                        if (|w_in_res_keep) begin
                            w_state_nxt = FLUSH;
                        end else begin
                            w_pay_in[OW-1] = 1'b1;
                            w_state_nxt    = IDLE;
                        end
                    end
                end
            end
            FLUSH: begin
                if (w_pay_rdy) begin
                    w_pay_valid = 1'b1;
                    w_pay_in    = {1'b1, {HDR_BYTES{1'b0}}, r_res_keep,
                                   {HDR_BYTES{8'h00}}, r_res_data};
                    w_state_nxt = IDLE;
                end
            end
            DROP: begin
                w_s_ready = 1'b1;
                if (w_in_acc && bus.s_axis_tlast) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state    <= IDLE;
            r_res_data <= '0;
            r_res_keep <= '0;
            r_runt_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_res_load) begin
                r_res_data <= bus.s_axis_tdata[DATA_W-1:8*HDR_BYTES];
                r_res_keep <= w_in_res_keep;
            end
            if (w_runt_inc) r_runt_cnt <= sat_inc(r_runt_cnt);
        end
    end

`ifdef ETH_HDR_REMOVER_FILTER_EN
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)       r_drop_cnt <= '0;
        else if (w_drop_inc) r_drop_cnt <= sat_inc(r_drop_cnt);
    end
`endif

    assign runt_cnt          = r_runt_cnt;
    assign bus.s_axis_tready = w_s_ready;

    eth_axis_out_reg #(.W(OW)) u_pay_reg (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .i_data  (w_pay_in),
        .i_valid (w_pay_valid),
        .o_ready (w_pay_rdy),
        .o_data  (w_pay_out),
        .o_valid (bus.m_axis_tvalid),
        .i_ready (bus.m_axis_tready)
    );

    assign {bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata} = w_pay_out;

    eth_axis_out_reg #(.W(112)) u_meta_reg (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .i_data  (w_hdr),
        .i_valid (w_meta_load),
        .o_ready (w_meta_rdy),
        .o_data  (bus.m_meta_tdata),
        .o_valid (bus.m_meta_tvalid),
        .i_ready (bus.m_meta_tready)
    );
endmodule

// File: tb/tb_ethernet_header_remover.sv
// Bench for ethernet_header_remover: frame-level reference model (byte queues) with a
// per-cycle output compare process, directed frames and randomized traffic.
module tb_ethernet_header_remover;
    localparam int DATA_W = 512;
    localparam int NB     = DATA_W / 8;
    localparam int CNT_W  = 32;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [NB-1:0]     keep;
        logic              last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [47:0]      my_mac = 48'h0200_0000_0001;
    logic [CNT_W-1:0] runt_cnt, drop_cnt;

    ethernet_header_remover_if #(.DATA_W(DATA_W)) bus ();

    ethernet_header_remover #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .bus      (bus),
        .my_mac   (my_mac),
        .runt_cnt (runt_cnt),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    beat_t        exp_pay[$];
    logic [111:0] exp_meta[$];
    logic [7:0]   frm[$];
    int checks = 0, failures = 0;
    int exp_runt = 0, exp_drop = 0;
    int pay_cnt = 0, meta_cnt = 0;
    int pay_mode = 0, meta_mode = 0;   // 0 always ready, 1 toggle, 2 random, 3 held low

    logic [NB-1:0]   last_keep;
    logic            last_last;
    logic [111:0]    last_meta;
    logic [7:0]      sof_byte;
    logic            sof = 1'b1;
    logic            prev_pend = 1'b0, mprev = 1'b0;
    logic [DATA_W+NB:0] prev_val;
    logic [111:0]    mprev_val;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Sink ready generators
    always @(posedge clk) begin
        #1;
        case (pay_mode)
            0: bus.m_axis_tready = 1'b1;
            1: bus.m_axis_tready = (bus.m_axis_tready === 1'b1) ? 1'b0 : 1'b1;
            2: bus.m_axis_tready = ($urandom_range(0, 3) != 0);
            default: bus.m_axis_tready = 1'b0;
        endcase
        case (meta_mode)
            0: bus.m_meta_tready = 1'b1;
            1: bus.m_meta_tready = (bus.m_meta_tready === 1'b1) ? 1'b0 : 1'b1;
            2: bus.m_meta_tready = ($urandom_range(0, 2) != 0);
            default: bus.m_meta_tready = 1'b0;
        endcase
    end

    // Reference model: what one input frame must produce.
    task automatic expect_frame();
        int len;
        logic [111:0] m;
        beat_t b;
        len = frm.size();
        if (len <= 14) begin
            exp_runt++;
            return;
        end
        for (int i = 0; i < 6; i++) begin
            m[8*(5-i) +: 8]      = frm[i];
            m[48 + 8*(5-i) +: 8] = frm[6+i];
        end
        m[111:104] = frm[12];
        m[103:96]  = frm[13];
`ifdef ETH_HDR_REMOVER_FILTER_EN
        if (m[47:0] != my_mac && m[47:0] != 48'hFFFF_FFFF_FFFF) begin
            exp_drop++;
            return;
        end
`endif
        exp_meta.push_back(m);
        for (int off = 14; off < len; off += NB) begin
            b.data = '0;
            b.keep = '0;
            for (int j = 0; j < NB && off + j < len; j++) begin
                b.data[8*j +: 8] = frm[off+j];
                b.keep[j]        = 1'b1;
            end
            b.last = (off + NB >= len);
            exp_pay.push_back(b);
        end
    endtask

    task automatic make_frame(input int len, input logic [47:0] dst, input logic [15:0] et);
        frm.delete();
        for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
        for (int i = 0; i < 6 && i < len; i++) frm[i] = dst[8*(5-i) +: 8];
        if (len > 12) frm[12] = et[15:8];
        if (len > 13) frm[13] = et[7:0];
    endtask

    task automatic present_beat(input int off);
        int len;
        len = frm.size();
        bus.s_axis_tdata = '0;
        bus.s_axis_tkeep = '0;
        for (int j = 0; j < NB && off + j < len; j++) begin
            bus.s_axis_tdata[8*j +: 8] = frm[off+j];
            bus.s_axis_tkeep[j]        = 1'b1;
        end
        bus.s_axis_tlast  = (off + NB >= len);
        bus.s_axis_tvalid = 1'b1;
    endtask

    task automatic drive_beat(input int off, output bit ok);
        int n;
        n = 0;
        present_beat(off);
        do begin
            @(negedge clk);
            n++;
        end while (bus.s_axis_tready !== 1'b1 && n < 3000);
        if (bus.s_axis_tready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL s_axis_accept_timeout actual=stalled required=accepted");
            ok = 1'b0;
        end else begin
            @(posedge clk);
            ok = 1'b1;
        end
        #1;
        bus.s_axis_tvalid = 1'b0;
    endtask

    task automatic send_frame(input bit gaps);
        bit ok;
        expect_frame();
        for (int off = 0; off < frm.size(); off += NB) begin
            drive_beat(off, ok);
            if (!ok) return;
            if (gaps && $urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_pay.size() != 0 || exp_meta.size() != 0) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_pay_left"}, exp_pay.size(), 0);
        chk({name, "_meta_left"}, exp_meta.size(), 0);
    endtask

    // Compare process
    always @(negedge clk) begin
        beat_t e;
        logic [DATA_W-1:0] mask;
        if (!rst_n) begin
            prev_pend = 1'b0;
            mprev     = 1'b0;
            sof       = 1'b1;
        end else begin
            if (prev_pend) begin
                checks++;
                if (bus.m_axis_tvalid !== 1'b1 ||
                    {bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata} !== prev_val) begin
                    failures++;
                    $display("FAIL pay_hold actual_valid=%b required_valid=1 with data unchanged", bus.m_axis_tvalid);
                end
            end
            if (mprev) begin
                checks++;
                if (bus.m_meta_tvalid !== 1'b1 || bus.m_meta_tdata !== mprev_val) begin
                    failures++;
                    $display("FAIL meta_hold actual=%0h required=%0h", bus.m_meta_tdata, mprev_val);
                end
            end
            if (bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready === 1'b1) begin
                pay_cnt++;
                last_keep = bus.m_axis_tkeep;
                last_last = bus.m_axis_tlast;
                if (sof) sof_byte = bus.m_axis_tdata[7:0];
                sof = bus.m_axis_tlast;
                checks++;
                if (exp_pay.size() == 0) begin
                    failures++;
                    $display("FAIL pay_extra actual=beat required=none");
                end else begin
                    e = exp_pay.pop_front();
                    for (int j = 0; j < NB; j++) mask[8*j +: 8] = {8{e.keep[j]}};
                    if (bus.m_axis_tkeep !== e.keep || bus.m_axis_tlast !== e.last ||
                        (bus.m_axis_tdata & mask) !== (e.data & mask)) begin
                        failures++;
                        $display("FAIL pay_beat actual keep=%h last=%b data=%h required keep=%h last=%b data=%h",
                                 bus.m_axis_tkeep, bus.m_axis_tlast, bus.m_axis_tdata & mask,
                                 e.keep, e.last, e.data & mask);
                    end
                end
            end
            if (bus.m_meta_tvalid === 1'b1 && bus.m_meta_tready === 1'b1) begin
                meta_cnt++;
                last_meta = bus.m_meta_tdata;
                if (exp_meta.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL meta_extra actual=%0h required=none", bus.m_meta_tdata);
                end else begin
                    chk("meta", bus.m_meta_tdata, exp_meta.pop_front());
                end
            end
            prev_pend = (bus.m_axis_tvalid === 1'b1) && (bus.m_axis_tready !== 1'b1);
            prev_val  = {bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata};
            mprev     = (bus.m_meta_tvalid === 1'b1) && (bus.m_meta_tready !== 1'b1);
            mprev_val = bus.m_meta_tdata;
        end
    end

    initial begin
        int p0, m0, len, sel;
        bit ok;
        logic [47:0] dst;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tkeep  = '0;
        bus.s_axis_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pay_valid", bus.m_axis_tvalid, 0);
        chk("rst_meta_valid", bus.m_meta_tvalid, 0);
        chk("rst_runt_cnt", runt_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 60-byte single-beat frame
        p0 = pay_cnt; m0 = meta_cnt;
        make_frame(60, my_mac, 16'h0800);
        frm[14] = 8'hA5;
        send_frame(1'b0);
        drain("f60");
        chk("f60_pay_beats", pay_cnt - p0, 1);
        chk("f60_meta_count", meta_cnt - m0, 1);
        chk("f60_ethertype", last_meta[111:96], 16'h0800);
        chk("f60_dst", last_meta[47:0], 48'h0200_0000_0001);
        chk("f60_keep", last_keep, 64'h0000_3FFF_FFFF_FFFF);
        chk("f60_last", last_last, 1);
        chk("f60_byte0", sof_byte, 8'hA5);

        // 128-byte two-beat frame: 114 payload bytes = 64 + 50
        p0 = pay_cnt;
        make_frame(128, my_mac, 16'h86DD);
        frm[14] = 8'h3C;
        send_frame(1'b0);
        drain("f128");
        chk("f128_pay_beats", pay_cnt - p0, 2);
        chk("f128_last_keep", last_keep, 64'h0003_FFFF_FFFF_FFFF);
        chk("f128_byte0", sof_byte, 8'h3C);

        // Runt followed by a normal frame
        p0 = pay_cnt; m0 = meta_cnt;
        make_frame(14, my_mac, 16'h0800);
        send_frame(1'b0);
        make_frame(64, my_mac, 16'h0806);
        send_frame(1'b0);
        drain("runt");
        chk("runt_cnt", runt_cnt, 1);
        chk("runt_meta_count", meta_cnt - m0, 1);
        chk("runt_pay_beats", pay_cnt - p0, 1);

        // Back-to-back 200-byte frames, toggling payload ready, meta held off
        p0 = pay_cnt; m0 = meta_cnt;
        pay_mode = 1; meta_mode = 3;
        make_frame(200, my_mac, 16'h0800);
        send_frame(1'b0);
        make_frame(200, 48'hFFFF_FFFF_FFFF, 16'h0806);
        present_beat(0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_s_ready", bus.s_axis_tready, 0);
        end
        @(posedge clk);
        #1;
        meta_mode = 0;
        send_frame(1'b0);
        drain("b2b");
        chk("b2b_pay_beats", pay_cnt - p0, 6);
        chk("b2b_meta_count", meta_cnt - m0, 2);
        pay_mode = 0;

`ifdef ETH_HDR_REMOVER_FILTER_EN
        p0 = pay_cnt; m0 = meta_cnt;
        make_frame(180, 48'h0200_0000_0099, 16'h0800);
        send_frame(1'b0);
        drain("drop");
        chk("drop_cnt", drop_cnt, 1);
        chk("drop_pay_beats", pay_cnt - p0, 0);
        chk("drop_meta_count", meta_cnt - m0, 0);
        make_frame(100, 48'hFFFF_FFFF_FFFF, 16'h0800);
        send_frame(1'b0);
        drain("bcast");
        chk("bcast_meta_count", meta_cnt - m0, 1);
        chk("bcast_dst", last_meta[47:0], 48'hFFFF_FFFF_FFFF);
`endif

        // Randomized traffic
        pay_mode = 2; meta_mode = 2;
        for (int f = 0; f < 40; f++) begin
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 14) : $urandom_range(15, 300);
            sel = $urandom_range(0, 2);
            dst = (sel == 0) ? my_mac : (sel == 1) ? 48'hFFFF_FFFF_FFFF : {16'h0200, 32'($urandom)};
            make_frame(len, dst, 16'($urandom));
            send_frame(1'b1);
        end
        pay_mode = 0; meta_mode = 0;
        drain("rand");
        chk("rand_runt_cnt", runt_cnt, exp_runt);
        chk("rand_drop_cnt", drop_cnt, exp_drop);

        // Reset in the middle of a frame
        pay_mode = 3; meta_mode = 3;
        make_frame(200, my_mac, 16'h0800);
        drive_beat(0, ok);
        drive_beat(NB, ok);
        @(negedge clk);
        chk("pre_rst_pay_valid", bus.m_axis_tvalid, 1);
        chk("pre_rst_meta_valid", bus.m_meta_tvalid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pay_valid", bus.m_axis_tvalid, 0);
        chk("async_rst_meta_valid", bus.m_meta_tvalid, 0);
        chk("async_rst_runt_cnt", runt_cnt, 0);
        exp_runt = 0;
        exp_drop = 0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pay_mode = 0; meta_mode = 0;
        @(posedge clk);
        #1;
        p0 = pay_cnt;
        make_frame(60, my_mac, 16'h88B5);
        send_frame(1'b0);
        drain("post_rst");
        chk("post_rst_ethertype", last_meta[111:96], 16'h88B5);
        chk("post_rst_dst", last_meta[47:0], 48'h0200_0000_0001);
        chk("post_rst_pay_beats", pay_cnt - p0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
